// File: rtl/router_ingress_ctrl.sv
`default_nettype none
// router_ingress_ctrl: 1x3 router ingress FSM: header decode, one-byte holding register, FIFO write control, length/parity check.
// Optional saturating packet statistics (pkt_ok_cnt/pkt_err_cnt/pkt_drop_cnt) are built when ROUTER_PKT_STATS_EN is defined.
module router_ingress_ctrl #(
    parameter int STAT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] soft_reset,
    output logic       busy,
    output logic [7:0] dout,
    output logic [2:0] we,
    output logic       lfd_state,
    output logic       err,
    output logic       parity_done
`ifdef ROUTER_PKT_STATS_EN
    ,
    output logic [STAT_W-1:0] pkt_ok_cnt,
    output logic [STAT_W-1:0] pkt_err_cnt,
    output logic [STAT_W-1:0] pkt_drop_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_EMPTY = 3'd1,
        LFD        = 3'd2,
        DATA       = 3'd3,
        PARITY     = 3'd4,
        CHECK      = 3'd5,
        DROP       = 3'd6
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [1:0] addr_r;
    logic [7:0] hold;
    logic       hold_vld;
    logic [5:0] rem_cnt;
    logic [7:0] par_acc;
    logic [7:0] par_rx;
    logic       over_len;

    logic       sel_full;
    logic       sel_empty;
    logic       sel_srst;
    logic       hdr_empty;
    logic       wr;
    logic       accept;
    logic       abort;
    logic       hdr_take;
    logic       hdr_bad;
    logic       check_err;

    // Flags of the FIFO owned by the current packet, and of the one named by an incoming header.
    always_comb begin
        sel_full  = 1'b0;
        sel_empty = 1'b0;
        sel_srst  = 1'b0;
        case (addr_r)
            2'd0: begin sel_full = fifo_full[0]; sel_empty = fifo_empty[0]; sel_srst = soft_reset[0]; end
            2'd1: begin sel_full = fifo_full[1]; sel_empty = fifo_empty[1]; sel_srst = soft_reset[1]; end
            2'd2: begin sel_full = fifo_full[2]; sel_empty = fifo_empty[2]; sel_srst = soft_reset[2]; end
            default: ;
        endcase
        hdr_empty = 1'b0;
        case (data_in[1:0])
            2'd0:    hdr_empty = fifo_empty[0];
            2'd1:    hdr_empty = fifo_empty[1];
            2'd2:    hdr_empty = fifo_empty[2];
            default: hdr_empty = 1'b0;
        endcase
    end

    assign wr        = hold_vld & ~sel_full & ((state == DATA) | (state == PARITY));
    assign accept    = (state == DATA) & ~(hold_vld & sel_full);
    assign abort     = sel_srst & (state != IDLE) & (state != DROP);
    assign hdr_bad   = (state == IDLE) & pkt_valid & (data_in[1:0] == 2'd3);
    assign hdr_take  = (state == IDLE) & pkt_valid & (data_in[1:0] != 2'd3);
    assign check_err = (par_acc != par_rx) | (rem_cnt != 6'd0) | over_len;
    assign dout      = hold;

    always_comb begin
        we = 3'b000;
        if (wr) begin
            case (addr_r)
                2'd0:    we = 3'b001;
                2'd1:    we = 3'b010;
                2'd2:    we = 3'b100;
                default: we = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        lfd_state   = 1'b0;
        parity_done = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_valid) begin
                    if (data_in[1:0] == 2'd3) begin
                        state_nxt = DROP;
                    end else if (hdr_empty) begin
                        state_nxt = LFD;
                    end else begin
                        state_nxt = WAIT_EMPTY;
                    end
                end
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (sel_empty) begin
                    state_nxt = LFD;
                end
            end
            LFD: begin
                busy      = 1'b1;
                lfd_state = 1'b1;
                state_nxt = DATA;
            end
            DATA: begin
                busy = hold_vld & sel_full;
                if (accept && !pkt_valid) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                busy = 1'b1;
                if (wr) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                busy        = 1'b1;
                parity_done = ~abort;
                state_nxt   = IDLE;
            end
            DROP: begin
                if (!pkt_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = pkt_valid ? DROP : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r   <= 2'd0;
            hold     <= 8'd0;
            hold_vld <= 1'b0;
            rem_cnt  <= 6'd0;
            par_acc  <= 8'd0;
            par_rx   <= 8'd0;
            over_len <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (hdr_take) begin
                addr_r   <= data_in[1:0];
                hold     <= data_in;
                rem_cnt  <= data_in[7:2];
                par_acc  <= data_in;
                over_len <= 1'b0;
                err      <= 1'b0;
            end
            if (abort) begin
                hold_vld <= 1'b0;
            end else begin
                case (state)
                    LFD: hold_vld <= 1'b1;
                    DATA: begin
                        if (accept) begin
                            hold     <= data_in;
                            hold_vld <= 1'b1;
                            if (pkt_valid) begin
                                par_acc <= par_acc ^ data_in;
                                // Extra payload beyond len is remembered so it still flags err.
                                if (rem_cnt == 6'd0) begin
                                    over_len <= 1'b1;
                                end else begin
                                    rem_cnt <= rem_cnt - 6'd1;
                                end
                            end else begin
                                par_rx <= data_in;
                            end
                        end else if (wr) begin
                            hold_vld <= 1'b0;
                        end
                    end
                    PARITY: begin
                        if (wr) begin
                            hold_vld <= 1'b0;
                        end
                    end
                    CHECK:   err <= check_err;
                    default: ;
                endcase
            end
        end
    end

`ifdef ROUTER_PKT_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic stat_drop;
    logic stat_chk;

    assign stat_drop = hdr_bad | (abort & pkt_valid);
    assign stat_chk  = (state == CHECK) & ~abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_ok_cnt   <= '0;
            pkt_err_cnt  <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            if (stat_chk && !check_err && (pkt_ok_cnt != '1)) begin
                pkt_ok_cnt <= pkt_ok_cnt + STAT_ONE;
            end
            if (stat_chk && check_err && (pkt_err_cnt != '1)) begin
                pkt_err_cnt <= pkt_err_cnt + STAT_ONE;
            end
            if (stat_drop && (pkt_drop_cnt != '1)) begin
                pkt_drop_cnt <= pkt_drop_cnt + STAT_ONE;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_ingress_ctrl.sv
`default_nettype none
// Bench for router_ingress_ctrl: packet-level scoreboard (per-FIFO byte queues, per-packet err) plus directed scenarios.
module tb_router_ingress_ctrl;

    logic       clk;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       busy;
    logic [7:0] dout;
    logic [2:0] we;
    logic       lfd_state;
    logic       err;
    logic       parity_done;
`ifdef ROUTER_PKT_STATS_EN
    logic [15:0] pkt_ok_cnt;
    logic [15:0] pkt_err_cnt;
    logic [15:0] pkt_drop_cnt;
`endif

    router_ingress_ctrl #(.STAT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .pkt_valid(pkt_valid),
        .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .soft_reset(soft_reset),
        .busy(busy),
        .dout(dout),
        .we(we),
        .lfd_state(lfd_state),
        .err(err),
        .parity_done(parity_done)
`ifdef ROUTER_PKT_STATS_EN
        ,
        .pkt_ok_cnt(pkt_ok_cnt),
        .pkt_err_cnt(pkt_err_cnt),
        .pkt_drop_cnt(pkt_drop_cnt)
`endif
    );

    int         n_vec = 0;
    int         n_miss = 0;
    logic [8:0] exp_q [0:2][$];
    logic [7:0] wlog  [0:2][$];
    bit         err_exp_q[$];
    logic [7:0] pl_q[$];
    logic [7:0] ref_q[$];
    int         hdr_seq = 0;
    int         pd_cnt = 0;
    int         lfd_cnt = 0;
    int         n_valid = 0;
    int         exp_ok = 0;
    int         exp_err = 0;
    int         exp_drop = 0;
    bit         chk_en = 0;
    bit         rand_en = 0;
    logic [2:0] dir_full = 3'b000;
    logic [2:0] dir_empty = 3'b111;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    endtask

    initial begin
        #400000;
        n_miss++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
        summary();
        $finish;
    end

    // FIFO flag environment: random per cycle, or the directed values.
    initial begin
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        forever begin
            @(posedge clk);
            #2;
            if (rand_en) begin
                for (int i = 0; i < 3; i++) begin
                    fifo_full[i]  = ($urandom_range(0, 9) < 3);
                    fifo_empty[i] = ($urandom_range(0, 9) < 7);
                end
            end else begin
                fifo_full  = dir_full;
                fifo_empty = dir_empty;
            end
        end
    end

    // Scoreboard: every write must be the next expected byte of that FIFO; err follows completed packets.
    initial begin
        int         f;
        int         hdr_seen;
        logic [8:0] e;
        logic       err_model;
        logic       lfd_pending;
        logic       lfd_prev;
        hdr_seen    = 0;
        err_model   = 1'b0;
        lfd_pending = 1'b0;
        lfd_prev    = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (hdr_seen != hdr_seq) begin
                    hdr_seen  = hdr_seq;
                    err_model = 1'b0;
                end
                chk("err_level", err, err_model);
                chk("we_onehot", ($countones(we) > 1), 0);
                if (we != 3'b000) begin
                    f = we[0] ? 0 : (we[1] ? 1 : 2);
                    chk("we_when_full", fifo_full[f], 0);
                    if (exp_q[f].size() == 0) begin
                        chk("unexpected_write", we, 0);
                    end else begin
                        e = exp_q[f].pop_front();
                        chk("write_data", dout, e[7:0]);
                        if (e[8]) begin
                            chk("lfd_before_header", lfd_pending, 1);
                            lfd_pending = 1'b0;
                        end
                    end
                    wlog[f].push_back(dout);
                end
                chk("lfd_width", lfd_state & lfd_prev, 0);
                if (lfd_state && !lfd_prev) begin
                    lfd_cnt++;
                    lfd_pending = 1'b1;
                end
                lfd_prev = lfd_state;
                if (parity_done) begin
                    pd_cnt++;
                    if (err_exp_q.size() == 0) begin
                        chk("unexpected_parity_done", parity_done, 0);
                    end else begin
                        err_model = err_exp_q.pop_front();
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic v, input logic [7:0] d);
        pkt_valid = v;
        data_in   = d;
        forever begin
            @(negedge clk);
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pkt_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected effect of a whole packet: header, payload and parity land in FIFO addr in order.
    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] par);
        logic [7:0] x;
        bit         e;
        x = hdr;
        foreach (pl_q[k]) x ^= pl_q[k];
        if (hdr[1:0] == 2'd3) begin
            exp_drop++;
        end else begin
            e = (x != par) || (pl_q.size() != int'(hdr[7:2]));
            exp_q[hdr[1:0]].push_back({1'b1, hdr});
            foreach (pl_q[k]) exp_q[hdr[1:0]].push_back({1'b0, pl_q[k]});
            exp_q[hdr[1:0]].push_back({1'b0, par});
            err_exp_q.push_back(e);
            n_valid++;
            if (e) exp_err++;
            else exp_ok++;
        end
        send_byte(1'b1, hdr);
        if (hdr[1:0] != 2'd3) hdr_seq++;
        foreach (pl_q[k]) send_byte(1'b1, pl_q[k]);
        send_byte(1'b0, par);
        pkt_valid = 1'b0;
    endtask

    task automatic wait_pd(input int target);
        int n;
        n = 0;
        while (pd_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("parity_done_timeout", (pd_cnt >= target), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string name, input int f, input int base);
        chk(name, wlog[f].size() - base, ref_q.size());
        foreach (ref_q[k]) begin
            if (base + k < wlog[f].size()) chk(name, wlog[f][base + k], ref_q[k]);
        end
    endtask

    initial begin
        int         base;
        int         pd0;
        int         lfd0;
        int         rem;
        logic [1:0] addr;
        logic [5:0] len;
        int         n;
        logic [7:0] par;

        rst        = 1'b1;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        soft_reset = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_we", we, 0);
        chk("reset_dout", dout, 0);
        chk("reset_lfd", lfd_state, 0);
        chk("reset_err", err, 0);
        chk("reset_parity_done", parity_done, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Good packet to FIFO1.
        pd0  = pd_cnt;
        pl_q = '{8'h11, 8'h22, 8'h33};
        send_packet(8'h0D, 8'h0D);
        wait_pd(pd0 + 1);
        ref_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        chk_log("t1_fifo1_bytes", 1, 0);
        chk("t1_err", err, 0);
        chk("t1_lfd_count", lfd_cnt, 1);
        chk("t1_fifo0_writes", wlog[0].size(), 0);
        chk("t1_fifo2_writes", wlog[2].size(), 0);

        // Same packet with a bad parity byte.
        base = wlog[1].size();
        pd0  = pd_cnt;
        send_packet(8'h0D, 8'hFF);
        wait_pd(pd0 + 1);
        ref_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF};
        chk_log("t2_fifo1_bytes", 1, base);
        chk("t2_err", err, 1);

        // Invalid address is dropped without writes or backpressure.
        lfd0 = lfd_cnt;
        pl_q = '{8'hAA, 8'hBB};
        fork
            send_packet(8'h0F, 8'h1E);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("t3_busy", busy, 0);
                    chk("t3_we", we, 0);
                    chk("t3_lfd", lfd_state, 0);
                end
            end
        join
        idle(3);
        chk("t3_err_hold", err, 1);
        chk("t3_no_lfd", lfd_cnt, lfd0);

        // Destination FIFO not empty: wait with busy, then normal delivery.
        dir_empty = 3'b011;
        base = wlog[2].size();
        pd0  = pd_cnt;
        pl_q = '{8'h5A};
        fork
            send_packet(8'h06, 8'h5C);
            begin
                @(posedge clk);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("t4_wait_busy", busy, 1);
                    chk("t4_wait_lfd", lfd_state, 0);
                end
                @(posedge clk);
                #1;
                dir_empty = 3'b111;
            end
        join
        wait_pd(pd0 + 1);
        ref_q = '{8'h06, 8'h5A, 8'h5C};
        chk_log("t4_fifo2_bytes", 2, base);
        chk("t4_err", err, 0);

        // FIFO0 full for four cycles mid-payload.
        base = wlog[0].size();
        pd0  = pd_cnt;
        pl_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        fork
            send_packet(8'h14, 8'h15);
            begin
                repeat (3) @(posedge clk);
                #1;
                dir_full = 3'b001;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("t5_full_busy", busy, 1);
                    chk("t5_full_we0", we[0], 0);
                    chk("t5_full_dout", dout, 8'h01);
                end
                @(posedge clk);
                #1;
                dir_full = 3'b000;
            end
        join
        wait_pd(pd0 + 1);
        ref_q = '{8'h14, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h15};
        chk_log("t5_fifo0_bytes", 0, base);
        chk("t5_err", err, 0);

        // Soft reset of FIFO1 during payload: three bytes reach it, rest dropped.
        base = wlog[1].size();
        pd0  = pd_cnt;
        exp_q[1].push_back({1'b1, 8'h0D});
        exp_q[1].push_back({1'b0, 8'h11});
        exp_q[1].push_back({1'b0, 8'h22});
        n_valid++;
        exp_drop++;
        send_byte(1'b1, 8'h0D);
        hdr_seq++;
        send_byte(1'b1, 8'h11);
        send_byte(1'b1, 8'h22);
        soft_reset = 3'b010;
        send_byte(1'b1, 8'h33);
        soft_reset = 3'b000;
        send_byte(1'b0, 8'h0D);
        idle(6);
        ref_q = '{8'h0D, 8'h11, 8'h22};
        chk_log("t6_fifo1_bytes", 1, base);
        chk("t6_no_parity_done", pd_cnt, pd0);
        chk("t6_err", err, 0);

        // Random packets: addresses, lengths, length/parity errors, FIFO flags.
        rand_en = 1'b1;
        for (int p = 0; p < 60; p++) begin
            addr = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            len  = 6'($urandom_range(0, 7));
            n    = int'(len);
            rem  = $urandom_range(0, 9);
            if (rem == 0) n = n + 1;
            else if (rem == 1 && n > 0) n = n - 1;
            pl_q.delete();
            for (int k = 0; k < n; k++) pl_q.push_back(8'($urandom));
            par = {len, addr};
            foreach (pl_q[k]) par ^= pl_q[k];
            if ($urandom_range(0, 7) == 0) par = par ^ 8'h5A;
            send_packet({len, addr}, par);
            idle($urandom_range(0, 3));
        end
        rand_en   = 1'b0;
        dir_full  = 3'b000;
        dir_empty = 3'b111;

        rem = 1;
        for (int k = 0; k < 1000 && rem != 0; k++) begin
            @(posedge clk);
            rem = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + err_exp_q.size();
        end
        idle(4);
        chk("drain_pending", rem, 0);
        chk("lfd_total", lfd_cnt, n_valid);
        chk("parity_done_total", pd_cnt, exp_ok + exp_err);
`ifdef ROUTER_PKT_STATS_EN
        chk("stat_ok", pkt_ok_cnt, exp_ok);
        chk("stat_err", pkt_err_cnt, exp_err);
        chk("stat_drop", pkt_drop_cnt, exp_drop);
`endif
        summary();
        $finish;
    end

endmodule
`default_nettype wire
